// File: rtl/mfp_timer_bank.sv
// rtl/mfp_timer_bank.sv - bank of MFP68901-style down-counting timers with one-shot mode
// Optional channel cascade (k-1 timeout drives channel k event input): define MFP_TIMER_CASCADE_EN.
module mfp_timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                XCLK_I,
  input  logic                RST,
  input  logic [SW-1:0]       SEL,
  input  logic                DAT_WE,
  input  logic [WIDTH-1:0]    DAT_I,
  input  logic                CTRL_WE,
  input  logic [6:0]          CTRL_I,
  output logic [6:0]          CTRL_O,
  input  logic                RD_STB,
  output logic [WIDTH-1:0]    DAT_O,
  input  logic [CHANNELS-1:0] T_I,
  output logic [CHANNELS-1:0] T_O,
  output logic [CHANNELS-1:0] T_O_PULSE,
  output logic [CHANNELS-1:0] RUNNING
);

`ifdef MFP_TIMER_CASCADE_EN
  localparam logic [6:0] CTRL_KEEP = 7'b110_1111;
`else
  localparam logic [6:0] CTRL_KEEP = 7'b010_1111;
`endif

  logic [WIDTH-1:0]    cnt_q   [CHANNELS];
  logic [WIDTH-1:0]    data_q  [CHANNELS];
  logic [6:0]          ctrl_q  [CHANNELS];
  logic [7:0]          presc_q [CHANNELS];
  logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
  logic [CHANNELS-1:0] t_o_q, pulse_q;
  logic [WIDTH-1:0]    dat_o_q;

  logic [CHANNELS-1:0] sel_hit, wr_dat, wr_ctrl;
  logic [CHANNELS-1:0] stopped, evt_mode, tick, dec, timeout, presc_clr;
  logic [WIDTH-1:0]    reload [CHANNELS];
  logic [WIDTH-1:0]    cnt_sel;
  logic [6:0]          ctrl_sel;

`ifdef MFP_TIMER_CASCADE_EN
  logic [CHANNELS:0]   pulse_prev;
  assign pulse_prev = {pulse_q, 1'b0};
`endif

  // Terminal prescaler value (P-1) for the low three mode bits.
  function automatic logic [7:0] presc_last(input logic [2:0] p);
    case (p)
      3'd1:    presc_last = 8'd3;
      3'd2:    presc_last = 8'd9;
      3'd3:    presc_last = 8'd15;
      3'd4:    presc_last = 8'd49;
      3'd5:    presc_last = 8'd63;
      3'd6:    presc_last = 8'd99;
      3'd7:    presc_last = 8'd199;
      default: presc_last = 8'd0;
    endcase
  endfunction

  always_comb begin
    cnt_sel  = '0;
    ctrl_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k]  = (SEL == SW'(k));
      wr_dat[k]   = DAT_WE & sel_hit[k];
      wr_ctrl[k]  = CTRL_WE & sel_hit[k];
      stopped[k]  = (ctrl_q[k][3:0] == 4'd0);
      evt_mode[k] = (ctrl_q[k][3:0] == 4'd8);
      tick[k]     = ~stopped[k] & ~evt_mode[k] &
                    (presc_q[k] == presc_last(ctrl_q[k][2:0]));
      if (evt_mode[k]) begin
        dec[k] = sync2_q[k] & ~sync3_q[k];
`ifdef MFP_TIMER_CASCADE_EN
        if (k > 0 && ctrl_q[k][6]) dec[k] = pulse_prev[k];
`endif
      end else begin
        // Pulse modes gate the prescaler ticks with the synchronised input.
        dec[k] = tick[k] & (~ctrl_q[k][3] | sync2_q[k]);
      end
      timeout[k]   = dec[k] & (cnt_q[k] == WIDTH'(1));
      reload[k]    = wr_dat[k] ? DAT_I : data_q[k];
      presc_clr[k] = stopped[k] | evt_mode[k] | tick[k] |
                     (wr_ctrl[k] & (CTRL_I[2:0] != ctrl_q[k][2:0]));
      if (sel_hit[k]) begin
        cnt_sel  = cnt_q[k];
        ctrl_sel = ctrl_q[k];
      end
    end
  end

  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k]   <= '0;
        data_q[k]  <= '0;
        ctrl_q[k]  <= '0;
        presc_q[k] <= '0;
      end
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      t_o_q   <= '0;
      pulse_q <= '0;
      dat_o_q <= '0;
    end else begin
      sync1_q <= T_I;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      pulse_q <= timeout;
      if (RD_STB) dat_o_q <= cnt_sel;
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_dat[k]) data_q[k] <= DAT_I;
        if (timeout[k])                   cnt_q[k] <= reload[k];
        else if (dec[k])                  cnt_q[k] <= cnt_q[k] - WIDTH'(1);
        else if (wr_dat[k] && stopped[k]) cnt_q[k] <= DAT_I;
        presc_q[k] <= presc_clr[k] ? 8'd0 : presc_q[k] + 8'd1;
        // A control write landing on a one-shot timeout wins over the auto-stop.
        if (wr_ctrl[k])                      ctrl_q[k] <= CTRL_I & CTRL_KEEP;
        else if (timeout[k] && ctrl_q[k][5]) ctrl_q[k][3:0] <= 4'd0;
        if (wr_ctrl[k] && CTRL_I[4]) t_o_q[k] <= 1'b0;
        else if (timeout[k])         t_o_q[k] <= ~t_o_q[k];
      end
    end
  end

  assign CTRL_O    = ctrl_sel;
  assign DAT_O     = dat_o_q;
  assign T_O       = t_o_q;
  assign T_O_PULSE = pulse_q;
  assign RUNNING   = ~stopped;

endmodule

// File: tb/tb_mfp_timer_bank.sv
// tb/tb_mfp_timer_bank.sv - directed plus randomized check of mfp_timer_bank against a behavioural model
module tb_mfp_timer_bank;
  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int SWB = 2;
  localparam int MASK = (1 << W) - 1;
`ifdef MFP_TIMER_CASCADE_EN
  localparam int KEEP = 'h6F;
`else
  localparam int KEEP = 'h2F;
`endif

  logic           clk;
  logic           RST;
  logic [SWB-1:0] SEL;
  logic           DAT_WE;
  logic [W-1:0]   DAT_I;
  logic           CTRL_WE;
  logic [6:0]     CTRL_I;
  logic [6:0]     CTRL_O;
  logic           RD_STB;
  logic [W-1:0]   DAT_O;
  logic [CH-1:0]  T_I;
  logic [CH-1:0]  T_O;
  logic [CH-1:0]  T_O_PULSE;
  logic [CH-1:0]  RUNNING;

  mfp_timer_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .XCLK_I(clk), .RST(RST), .SEL(SEL), .DAT_WE(DAT_WE), .DAT_I(DAT_I),
    .CTRL_WE(CTRL_WE), .CTRL_I(CTRL_I), .CTRL_O(CTRL_O), .RD_STB(RD_STB),
    .DAT_O(DAT_O), .T_I(T_I), .T_O(T_O), .T_O_PULSE(T_O_PULSE), .RUNNING(RUNNING)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: counts, prescaler phase and a T_I sample history.
  int m_cnt [CH], m_data [CH], m_ctrl [CH], m_ph [CH];
  bit m_to [CH], m_pulse [CH];
  int m_dato;
  logic [CH-1:0] h1, h2, h3;
  int ptab [8] = '{1, 4, 10, 16, 50, 64, 100, 200};

  always @(posedge clk) begin : model
    int mode, p, nd;
    bit stp, evt, tck, dec, tmo, wd, wc;
    int n_cnt [CH], n_data [CH], n_ctrl [CH], n_ph [CH];
    bit n_to [CH], n_pulse [CH];
    cyc++;
    if (RST) begin
      for (int k = 0; k < CH; k++) begin
        m_cnt[k] = 0; m_data[k] = 0; m_ctrl[k] = 0; m_ph[k] = 0;
        m_to[k] = 0; m_pulse[k] = 0;
      end
      h1 = '0; h2 = '0; h3 = '0;
      m_dato = 0;
      chk_en = 1;
    end else begin
      for (int k = 0; k < CH; k++) begin
        mode = m_ctrl[k] & 15;
        p    = ptab[mode & 7];
        stp  = (mode == 0);
        evt  = (mode == 8);
        tck  = !stp && !evt && (m_ph[k] == p - 1);
        if (evt) begin
          dec = h2[k] && !h3[k];
`ifdef MFP_TIMER_CASCADE_EN
          if (k > 0) begin
            if (m_ctrl[k][6]) dec = m_pulse[k-1];
          end
`endif
        end else begin
          dec = tck && (mode < 8 || h2[k]);
        end
        tmo = dec && (m_cnt[k] == 1);
        wd  = DAT_WE && (SEL == k);
        wc  = CTRL_WE && (SEL == k);
        nd  = wd ? int'(DAT_I) : m_data[k];
        n_data[k] = nd;
        if (tmo)           n_cnt[k] = nd;
        else if (dec)      n_cnt[k] = (m_cnt[k] - 1) & MASK;
        else if (wd && stp) n_cnt[k] = int'(DAT_I);
        else               n_cnt[k] = m_cnt[k];
        n_ph[k] = (stp || evt) ? 0 : (m_ph[k] + 1) % p;
        if (wc && ((int'(CTRL_I) & 7) != (mode & 7))) n_ph[k] = 0;
        if (wc)                       n_ctrl[k] = int'(CTRL_I) & KEEP;
        else if (tmo && m_ctrl[k][5]) n_ctrl[k] = m_ctrl[k] & 'h70;
        else                          n_ctrl[k] = m_ctrl[k];
        if (wc && CTRL_I[4]) n_to[k] = 0;
        else if (tmo)        n_to[k] = !m_to[k];
        else                 n_to[k] = m_to[k];
        n_pulse[k] = tmo;
      end
      if (RD_STB) m_dato = m_cnt[SEL];
      for (int k = 0; k < CH; k++) begin
        m_cnt[k] = n_cnt[k]; m_data[k] = n_data[k]; m_ctrl[k] = n_ctrl[k];
        m_ph[k] = n_ph[k]; m_to[k] = n_to[k]; m_pulse[k] = n_pulse[k];
      end
      h3 = h2; h2 = h1; h1 = T_I;
    end
  end

  always @(negedge clk) begin : compare
    logic [CH-1:0] e_to, e_pl, e_run;
    if (chk_en) begin
      for (int k = 0; k < CH; k++) begin
        e_to[k]  = m_to[k];
        e_pl[k]  = m_pulse[k];
        e_run[k] = (m_ctrl[k] & 15) != 0;
      end
      check("T_O", 32'(T_O), 32'(e_to));
      check("T_O_PULSE", 32'(T_O_PULSE), 32'(e_pl));
      check("RUNNING", 32'(RUNNING), 32'(e_run));
      check("CTRL_O", 32'(CTRL_O), 32'(m_ctrl[SEL]));
      check("DAT_O", 32'(DAT_O), 32'(m_dato));
    end
  end

  int pulse_cnt [CH], last_cyc [CH], last_int [CH];

  always @(negedge clk) begin : monitor
    if (chk_en) begin
      for (int k = 0; k < CH; k++) begin
        if (T_O_PULSE[k] === 1'b1) begin
          if (pulse_cnt[k] > 0) last_int[k] = cyc - last_cyc[k];
          last_cyc[k] = cyc;
          pulse_cnt[k]++;
        end
      end
    end
  end

  task automatic clear_mon();
    for (int k = 0; k < CH; k++) begin
      pulse_cnt[k] = 0; last_cyc[k] = 0; last_int[k] = 0;
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_dat(input int ch, input int v);
    SEL = SWB'(ch); DAT_I = W'(v); DAT_WE = 1'b1;
    step();
    DAT_WE = 1'b0;
  endtask

  task automatic wr_ctrl(input int ch, input int v);
    SEL = SWB'(ch); CTRL_I = 7'(v); CTRL_WE = 1'b1;
    step();
    CTRL_WE = 1'b0;
  endtask

  task automatic snap(input int ch);
    SEL = SWB'(ch); RD_STB = 1'b1;
    step();
    RD_STB = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    clear_mon();
  endtask

  initial begin : main
    int e, c0, sel_m, mode;
    RST = 1'b1; SEL = '0; DAT_WE = 0; DAT_I = '0; CTRL_WE = 0; CTRL_I = '0;
    RD_STB = 0; T_I = '0;
    clear_mon();
    step(3);
    RST = 1'b0;
    check("rst_t_o", 32'(T_O), 0);
    check("rst_pulse", 32'(T_O_PULSE), 0);
    check("rst_running", 32'(RUNNING), 0);
    check("rst_dat_o", 32'(DAT_O), 0);

    // Delay mode, P=4, data=3.
    wr_dat(0, 3);
    wr_ctrl(0, 'h01);
    snap(0);
    check("delay_snap3", 32'(DAT_O), 3);
    step(3); snap(0);
    check("delay_snap2", 32'(DAT_O), 2);
    step(3); snap(0);
    check("delay_snap1", 32'(DAT_O), 1);
    step(30);
    check("delay_pulses", pulse_cnt[0], 3);
    check("delay_period", last_int[0], 12);
    check("delay_t_o", 32'(T_O[0]), 1);

    // Event mode.
    do_reset();
    wr_dat(1, 2);
    wr_ctrl(1, 'h08);
    T_I[1] = 1'b1; step(3);
    T_I[1] = 1'b0; step(3);
    T_I[1] = 1'b1; c0 = cyc;
    step(6);
    T_I[1] = 1'b0;
    check("event_pulses", pulse_cnt[1], 1);
    check("event_latency", last_cyc[1] - c0, 3);
    snap(1);
    check("event_reload", 32'(DAT_O), 2);
    check("model_event_cnt", m_cnt[1], 2);

    // One-shot.
    do_reset();
    wr_dat(2, 5);
    wr_ctrl(2, 'h21);
    e = cyc;
    step(25);
    check("oneshot_pulses", pulse_cnt[2], 1);
    check("oneshot_time", last_cyc[2] - e, 20);
    SEL = 2'd2; #1;
    check("oneshot_ctrl", 32'(CTRL_O), 'h20);
    check("oneshot_running", 32'(RUNNING[2]), 0);
    step(200);
    check("oneshot_no_more", pulse_cnt[2], 1);

    // Data write while running.
    do_reset();
    wr_dat(0, 3);
    wr_ctrl(0, 'h01);
    step(6);
    wr_dat(0, 5);
    snap(0);
    check("run_write_cnt", 32'(DAT_O), 2);
    step(60);
    check("run_write_pulses", pulse_cnt[0], 3);
    check("run_write_period", last_int[0], 20);

    // data=0 wraps through 256 counts.
    do_reset();
    wr_dat(3, 0);
    wr_ctrl(3, 'h01);
    step(2100);
    check("wrap_pulses", pulse_cnt[3], 2);
    check("wrap_period", last_int[3], 1024);

    // Reset mid-count.
    do_reset();
    wr_dat(0, 3);
    wr_ctrl(0, 'h01);
    step(5);
    RST = 1'b1; step(); RST = 1'b0;
    clear_mon();
    check("midrst_t_o", 32'(T_O), 0);
    check("midrst_pulse", 32'(T_O_PULSE), 0);
    check("midrst_running", 32'(RUNNING), 0);
    check("midrst_dat_o", 32'(DAT_O), 0);
    step(50);
    check("midrst_no_pulse", pulse_cnt[0], 0);

    // Cascade.
    do_reset();
    wr_dat(0, 2);
    wr_dat(1, 3);
    wr_ctrl(1, 'h48);
    wr_ctrl(0, 'h01);
    step(120);
    SEL = 2'd1; #1;
`ifdef MFP_TIMER_CASCADE_EN
    check("casc_ctrl", 32'(CTRL_O), 'h48);
    check("casc_pulses", 32'(pulse_cnt[1] >= 3), 1);
    check("casc_period", last_int[1], 24);
`else
    check("casc_ctrl", 32'(CTRL_O), 'h08);
    check("casc_no_pulse", pulse_cnt[1], 0);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      RST     = ($urandom_range(0, 599) == 0);
      SEL     = SWB'($urandom_range(0, CH - 1));
      DAT_WE  = ($urandom_range(0, 7) == 0);
      DAT_I   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      CTRL_WE = ($urandom_range(0, 11) == 0);
      sel_m   = $urandom_range(0, 5);
      case (sel_m)
        0: mode = 0;
        1: mode = 1;
        2: mode = 2;
        3: mode = 8;
        4: mode = 9;
        default: mode = $urandom_range(0, 15);
      endcase
      CTRL_I  = {1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0), 4'(mode)};
      RD_STB  = ($urandom_range(0, 2) == 0);
      T_I     = T_I ^ (CH'($urandom) & CH'($urandom));
      step();
    end
    RST = 1'b0; DAT_WE = 0; CTRL_WE = 0; RD_STB = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
